// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; result lands 33 edges after accept (MUL: 1 edge when MULDIV_FAST_MULT_EN).
// Backpressure: busy stalls the controller; start, hi_we and lo_we are ignored while busy, never queued.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op_in,
    input  logic [WIDTH-1:0] rs_data_in,
    input  logic [WIDTH-1:0] rt_data_in,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             state, state_nxt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               sa_q, sb_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, mcand;

    // Operand conditioning at accept: magnitudes only for signed ops
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] a_in, b_in;
    assign rs_neg = ~op_in[0] & rs_data_in[WIDTH-1];
    assign rt_neg = ~op_in[0] & rt_data_in[WIDTH-1];
    assign a_in   = rs_neg ? -rs_data_in : rs_data_in;
    assign b_in   = rt_neg ? -rt_data_in : rt_data_in;

    // Restoring-division step on acc = {remainder, dividend/quotient}
    logic [WIDTH:0]   rem_sh, rem_diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nxt;
    assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    assign rem_diff = rem_sh - {1'b0, b_q};
    assign q_bit    = ~rem_diff[WIDTH];
    assign rem_nxt  = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];

    // Sign correction applied in FIX
    logic [2*WIDTH-1:0] prod_mag, prod_res;
    logic [WIDTH-1:0]   quo, rem, raw_rs;
`ifdef MULDIV_FAST_MULT_EN
    assign prod_mag = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`else
    assign prod_mag = acc;
`endif
    assign prod_res = (sa_q ^ sb_q) ? -prod_mag : prod_mag;
    assign quo      = (sa_q ^ sb_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem      = sa_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign raw_rs   = sa_q ? -a_q : a_q;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) begin
`ifdef MULDIV_FAST_MULT_EN
                state_nxt = op_in[1] ? S_DIV : S_FIX;
`else
                state_nxt = op_in[1] ? S_DIV : S_MUL;
`endif
            end
            S_MUL:   if (cnt == CW'(WIDTH-1)) state_nxt = S_FIX;
            S_DIV:   if (cnt == CW'(WIDTH-1)) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            done   <= 1'b0;
            div0   <= 1'b0;
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hi_we) hi_out <= rs_data_in;
                    if (lo_we) lo_out <= rs_data_in;
                    if (start) begin
                        op_q  <= op_in;
                        a_q   <= a_in;
                        b_q   <= b_in;
                        sa_q  <= rs_neg;
                        sb_q  <= rt_neg;
                        cnt   <= '0;
                        div0  <= 1'b0;
                        acc   <= op_in[1] ? {{WIDTH{1'b0}}, a_in} : '0;
                        mcand <= {{WIDTH{1'b0}}, a_in};
                    end
                end
                S_MUL: begin
                    if (b_q[0]) acc <= acc + mcand;
                    mcand <= mcand << 1;
                    b_q   <= b_q >> 1;
                    cnt   <= cnt + 1'b1;
                end
                S_DIV: begin
                    acc <= {rem_nxt, acc[WIDTH-2:0], q_bit};
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    done <= 1'b1;
                    if (!op_q[1]) begin
                        {hi_out, lo_out} <= prod_res;
                    end else if (b_q == '0) begin
                        hi_out <= raw_rs;
                        lo_out <= '1;
                        div0   <= 1'b1;
                    end else begin
                        hi_out <= rem;
                        lo_out <= quo;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
